// File: rtl/wb_rr_arbiter2_if.sv
// Pipelined Wishbone B4 port bundle shared by the two masters and the slave side
// of wb_rr_arbiter2. dat_w flows master->slave, dat_r flows slave->master.
`timescale 1ns/1ps
interface wb_rr_arbiter2_if #(
    parameter int ADDR_W = 30
);
    logic              cyc;
    logic              stb;
    logic [ADDR_W-1:0] adr;
    logic [3:0]        sel;
    logic              we;
    logic [31:0]       dat_w;
    logic [31:0]       dat_r;
    logic              ack;
    logic              err;
    logic              rty;
    logic              stall;

    modport master (
        output cyc, stb, adr, sel, we, dat_w,
        input  dat_r, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, adr, sel, we, dat_w,
        output dat_r, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave, one
// transaction in flight at a time, with a watchdog that turns a hung access into err.
//
// state | meaning
// IDLE  | no owner; arbitrate, latch the winner's request
// ISSUE | s_stb high for the owner until the slave stops stalling
// WAIT  | strobe taken; wait for ack/err/rty or watchdog expiry
`timescale 1ns/1ps
module wb_rr_arbiter2 #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    wb_rr_arbiter2_if.slave  m0,
    wb_rr_arbiter2_if.slave  m1,
    wb_rr_arbiter2_if.master s
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  wd_cnt;

    logic              req0;
    logic              req1;
    logic              grant;
    logic              owner_cyc;
    logic              slv_resp;
    logic              wd_hit;
    logic [ADDR_W-1:0] adr_mux;

    always_comb begin
        req0      = m0.cyc & m0.stb;
        req1      = m1.cyc & m1.stb;
        // on a tie the master that did not own the bus last time wins
        grant     = (req0 & req1) ? ~last_grant : req1;
        owner_cyc = owner ? m1.cyc : m0.cyc;
        slv_resp  = s.ack | s.err | s.rty;
        wd_hit    = (TIMEOUT != 0) && (wd_cnt == WD_LIMIT);
        adr_mux   = grant ? m1.adr : m0.adr;
    end

    assign m0.stall = req0 & ~((state == IDLE) & ~grant);
    assign m1.stall = req1 & ~((state == IDLE) &  grant);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            s.cyc      <= 1'b0;
            s.stb      <= 1'b0;
            s.adr      <= '0;
            s.sel      <= '0;
            s.we       <= 1'b0;
            s.dat_w    <= '0;
            m0.ack     <= 1'b0;
            m0.err     <= 1'b0;
            m0.rty     <= 1'b0;
            m0.dat_r   <= '0;
            m1.ack     <= 1'b0;
            m1.err     <= 1'b0;
            m1.rty     <= 1'b0;
            m1.dat_r   <= '0;
        end else begin
            m0.ack <= 1'b0;
            m0.err <= 1'b0;
            m0.rty <= 1'b0;
            m1.ack <= 1'b0;
            m1.err <= 1'b0;
            m1.rty <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner   <= grant;
                        s.adr   <= adr_mux;
                        s.sel   <= grant ? m1.sel   : m0.sel;
                        s.we    <= grant ? m1.we    : m0.we;
                        s.dat_w <= grant ? m1.dat_w : m0.dat_w;
                        s.cyc   <= 1'b1;
                        s.stb   <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (!owner_cyc) begin
                        s.cyc      <= 1'b0;
                        s.stb      <= 1'b0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if ((state == WAIT) && slv_resp) begin
                        // a slave response beats a watchdog expiry in the same cycle
                        if (s.ack) begin
                            if (owner) begin
                                m1.ack   <= 1'b1;
                                m1.dat_r <= s.dat_r;
                            end else begin
                                m0.ack   <= 1'b1;
                                m0.dat_r <= s.dat_r;
                            end
                        end else if (s.err) begin
                            if (owner) m1.err <= 1'b1;
                            else       m0.err <= 1'b1;
                        end else begin
                            if (owner) m1.rty <= 1'b1;
                            else       m0.rty <= 1'b1;
                        end
                        s.cyc      <= 1'b0;
                        s.stb      <= 1'b0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (wd_hit) begin
                        if (owner) m1.err <= 1'b1;
                        else       m0.err <= 1'b1;
                        s.cyc      <= 1'b0;
                        s.stb      <= 1'b0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end else begin
                        if (TIMEOUT != 0) wd_cnt <= wd_cnt + CNT_W'(1);
                        if ((state == ISSUE) && !s.stall) begin
                            s.stb <= 1'b0;
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Randomized bench for wb_rr_arbiter2: two master drivers, a stalling slave with
// random latency, and a cycle-stamped transaction model of the arbitration rules.
`timescale 1ns/1ps
module tb_wb_rr_arbiter2;
    localparam int ADDR_W  = 30;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arbiter2_if #(.ADDR_W(ADDR_W)) m0_if ();
    wb_rr_arbiter2_if #(.ADDR_W(ADDR_W)) m1_if ();
    wb_rr_arbiter2_if #(.ADDR_W(ADDR_W)) s_if ();

    wb_rr_arbiter2 #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if)
    );

    // master-side drive and observation, indexed by master number
    logic              mc[2];
    logic              ms[2];
    logic              mwe[2];
    logic [ADDR_W-1:0] madr[2];
    logic [3:0]        msel[2];
    logic [31:0]       mdat[2];
    logic              mack[2];
    logic              merr[2];
    logic              mrty[2];
    logic              mstall[2];
    logic [31:0]       mrd[2];

    assign m0_if.cyc = mc[0];   assign m1_if.cyc = mc[1];
    assign m0_if.stb = ms[0];   assign m1_if.stb = ms[1];
    assign m0_if.we  = mwe[0];  assign m1_if.we  = mwe[1];
    assign m0_if.adr = madr[0]; assign m1_if.adr = madr[1];
    assign m0_if.sel = msel[0]; assign m1_if.sel = msel[1];
    assign m0_if.dat_w = mdat[0]; assign m1_if.dat_w = mdat[1];
    assign mack[0] = m0_if.ack;   assign mack[1] = m1_if.ack;
    assign merr[0] = m0_if.err;   assign merr[1] = m1_if.err;
    assign mrty[0] = m0_if.rty;   assign mrty[1] = m1_if.rty;
    assign mstall[0] = m0_if.stall; assign mstall[1] = m1_if.stall;
    assign mrd[0] = m0_if.dat_r;  assign mrd[1] = m1_if.dat_r;

    logic        sl_stall, sl_ack, sl_err, sl_rty, inj_ack;
    logic [31:0] sl_dat;
    assign s_if.stall = sl_stall;
    assign s_if.ack   = sl_ack | inj_ack;
    assign s_if.err   = sl_err;
    assign s_if.rty   = sl_rty;
    assign s_if.dat_r = sl_dat;

    int  n_checks = 0;
    int  n_errors = 0;
    int  force_lat = -1;
    int  stall_pct = 0;
    bit  never_resp = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // slave: random stall (at most 3 in a row), response 0..3 cycles after accept
    initial begin : slave_bfm
        bit acc_pend;
        bit busy_s;
        int lat;
        int nst;
        int kind;
        acc_pend = 0; busy_s = 0; lat = 0; nst = 0;
        sl_stall = 0; sl_ack = 0; sl_err = 0; sl_rty = 0; sl_dat = '0;
        forever begin
            @(posedge clk); #1;
            sl_ack = 0; sl_err = 0; sl_rty = 0;
            if (!rst_n || !s_if.cyc) begin
                acc_pend = 0; busy_s = 0; sl_stall = 0; nst = 0;
            end else begin
                if (acc_pend) begin
                    acc_pend = 0;
                    busy_s   = 1;
                    lat = (force_lat >= 0) ? force_lat : int'($urandom_range(3));
                end
                if (busy_s && !never_resp) begin
                    if (lat == 0) begin
                        busy_s = 0;
                        kind = int'($urandom_range(9));
                        sl_dat = $urandom;
                        if (kind < 8)       sl_ack = 1;
                        else if (kind == 8) sl_err = 1;
                        else                sl_rty = 1;
                    end else begin
                        lat--;
                    end
                end
                if (s_if.stb && !busy_s) begin
                    sl_stall = (nst < 3) && (int'($urandom_range(99)) < stall_pct);
                    nst = sl_stall ? nst + 1 : 0;
                    acc_pend = !sl_stall;
                end else begin
                    sl_stall = 0;
                end
            end
        end
    end

    // one master transaction; abort_after >= 0 drops cyc that many cycles into the wait
    task automatic m_xfer(input int m, input int abort_after);
        bit got;
        bit aborted;
        madr[m] = ADDR_W'($urandom);
        msel[m] = 4'($urandom);
        mwe[m]  = 1'($urandom);
        mdat[m] = $urandom;
        mc[m] = 1; ms[m] = 1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = !mstall[m];
        end
        @(posedge clk); #1;
        ms[m] = 0;
        check_val($sformatf("m%0d_accept_bound", m), 64'(got), 64'd1);
        if (!got) begin
            mc[m] = 0;
            return;
        end
        got = 0; aborted = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mack[m] | merr[m] | mrty[m]) begin got = 1; break; end
            if (i == abort_after) begin aborted = 1; break; end
        end
        @(posedge clk); #1;
        mc[m] = 0;
        if (!aborted) check_val($sformatf("m%0d_resp_bound", m), 64'(got), 64'd1);
    endtask

    task automatic m_run(input int m, input int ntx);
        int g;
        for (int k = 0; k < ntx; k++) begin
            g = int'($urandom_range(2));
            repeat (g) begin @(posedge clk); #1; end
            m_xfer(m, ($urandom_range(9) == 0) ? int'($urandom_range(3)) : -1);
        end
    endtask

    // reference model: one transaction record stamped with its issue cycle
    int              cyc_n = 0;
    bit              t_busy = 0;
    bit              t_stb = 0;
    int              t_own = 0;
    int              t_last = 1;
    int              t_issue = 0;
    logic [ADDR_W-1:0] t_adr;
    logic [3:0]      t_sel;
    logic            t_we;
    logic [31:0]     t_dat;
    int              p_kind = 0;
    int              p_m = 0;
    logic [31:0]     hold[2] = '{32'h0, 32'h0};

    always @(negedge clk) begin : ref_model
        bit req[2];
        bit exp_stall[2];
        int w;
        int age;
        cyc_n++;
        if (!rst_n) begin
            check_val("rst_s_cyc", 64'(s_if.cyc), 64'd0);
            check_val("rst_s_stb", 64'(s_if.stb), 64'd0);
            check_val("rst_s_adr", 64'(s_if.adr), 64'd0);
            check_val("rst_s_dat", 64'(s_if.dat_w), 64'd0);
            for (int m = 0; m < 2; m++) begin
                check_val($sformatf("rst_m%0d_resp", m), 64'({mack[m], merr[m], mrty[m]}), 64'd0);
                check_val($sformatf("rst_m%0d_dat", m), 64'(mrd[m]), 64'd0);
            end
            t_busy = 0; t_stb = 0; t_last = 1; p_kind = 0;
            hold[0] = '0; hold[1] = '0;
        end else begin
            check_val("s_cyc", 64'(s_if.cyc), 64'(t_busy));
            check_val("s_stb", 64'(s_if.stb), 64'(t_busy && t_stb));
            if (t_busy) begin
                check_val("s_adr", 64'(s_if.adr), 64'(t_adr));
                check_val("s_sel", 64'(s_if.sel), 64'(t_sel));
                check_val("s_we",  64'(s_if.we),  64'(t_we));
                check_val("s_dat", 64'(s_if.dat_w), 64'(t_dat));
            end
            for (int m = 0; m < 2; m++) begin
                check_val($sformatf("m%0d_ack", m), 64'(mack[m]), 64'(p_kind == 1 && p_m == m));
                check_val($sformatf("m%0d_err", m), 64'(merr[m]), 64'(p_kind == 2 && p_m == m));
                check_val($sformatf("m%0d_rty", m), 64'(mrty[m]), 64'(p_kind == 3 && p_m == m));
                check_val($sformatf("m%0d_rdat", m), 64'(mrd[m]), 64'(hold[m]));
                req[m] = mc[m] && ms[m];
                exp_stall[m] = req[m];
            end
            p_kind = 0;
            if (!t_busy) begin
                if (req[0] || req[1]) begin
                    w = (req[0] && req[1]) ? 1 - t_last : (req[0] ? 0 : 1);
                    exp_stall[w] = 0;
                    t_busy = 1; t_stb = 1; t_own = w; t_issue = cyc_n + 1;
                    t_adr = madr[w]; t_sel = msel[w]; t_we = mwe[w]; t_dat = mdat[w];
                end
            end else begin
                age = cyc_n - t_issue;
                if (!mc[t_own]) begin
                    t_busy = 0; t_last = t_own;
                end else if (!t_stb && (s_if.ack || s_if.err || s_if.rty)) begin
                    p_kind = s_if.ack ? 1 : (s_if.err ? 2 : 3);
                    p_m = t_own;
                    if (s_if.ack) hold[t_own] = s_if.dat_r;
                    t_busy = 0; t_last = t_own;
                end else if (age >= TIMEOUT) begin
                    p_kind = 2; p_m = t_own;
                    t_busy = 0; t_last = t_own;
                end else if (t_stb && !s_if.stall) begin
                    t_stb = 0;
                end
            end
            check_val("m0_stall", 64'(mstall[0]), 64'(exp_stall[0]));
            check_val("m1_stall", 64'(mstall[1]), 64'(exp_stall[1]));
        end
    end

    initial begin : main
        for (int m = 0; m < 2; m++) begin
            mc[m] = 0; ms[m] = 0; mwe[m] = 0; madr[m] = '0; msel[m] = '0; mdat[m] = '0;
        end
        inj_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // single m0 transfer with a prompt slave
        m_xfer(0, -1);
        repeat (2) begin @(posedge clk); #1; end

        // held stall: three stall cycles then accept
        stall_pct = 100;
        m_xfer(1, -1);
        stall_pct = 30;

        // contended random traffic
        fork
            m_run(0, 40);
            m_run(1, 40);
        join

        // watchdog expiry, then a stray ack while idle
        stall_pct = 0;
        never_resp = 1;
        m_xfer(1, -1);
        never_resp = 0;
        @(posedge clk); #1 inj_ack = 1;
        @(posedge clk); #1 inj_ack = 0;

        // response lands exactly on the watchdog limit, then one cycle too late
        force_lat = 7;
        m_xfer(0, -1);
        force_lat = 8;
        m_xfer(0, -1);

        // owner abandons in WAIT while the other master queues
        force_lat = 5;
        fork
            m_xfer(0, 2);
            begin
                @(posedge clk); #1;
                m_xfer(1, -1);
            end
        join
        force_lat = -1;

        // asynchronous reset in the middle of WAIT, then a tie
        never_resp = 1;
        fork
            m_xfer(0, 3);
            begin
                repeat (4) @(posedge clk);
                #2 rst_n = 0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
            end
        join
        never_resp = 0;
        @(posedge clk); #1;
        fork
            m_xfer(0, -1);
            m_xfer(1, -1);
        join

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : global_bound
        #500000;
        n_errors++;
        $display("FAIL global_time_bound: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "time bound exceeded");
    end
endmodule
